// File: rtl/cl_ocl_csr.sv
// cl_ocl_csr: AXI-Lite CSR slave for the 3D rendering engine (start, frame-buffer base, IRQ, frame count).
// Independent write and read FSMs decode a small register map on the low DEC_W address bits.
module cl_ocl_csr #(
  parameter int unsigned DEC_W     = 8,
  parameter logic [31:0] VERSION   = 32'h3D00_0001,
  parameter bit          SLVERR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  input  logic        eng_busy,
  input  logic        eng_done,
  output logic        eng_start,
  output logic [63:0] fb_addr,
  output logic        irq
);

  localparam int unsigned IW = DEC_W - 2;

  localparam logic [IW-1:0] A_CTRL      = IW'(0);
  localparam logic [IW-1:0] A_STATUS    = IW'(1);
  localparam logic [IW-1:0] A_FB_LO     = IW'(2);
  localparam logic [IW-1:0] A_FB_HI     = IW'(3);
  localparam logic [IW-1:0] A_FRAME_CNT = IW'(4);
  localparam logic [IW-1:0] A_SCRATCH   = IW'(5);
  localparam logic [IW-1:0] A_VERSION   = IW'(6);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_UNMAP = SLVERR_EN ? 2'b10 : 2'b00;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic          awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IW-1:0] awidx_q, awidx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_en_q, irq_en_d, done_q, done_d, start_q, start_d, irq_q;
  logic [31:0]   fb_lo_q, fb_lo_d, fb_hi_q, fb_hi_d, scratch_q, scratch_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_data, rd_val;
  logic [3:0]    wr_strb;
  logic [1:0]    wr_resp, rd_resp;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{s_awaddr[31:DEC_W], s_awaddr[1:0], s_araddr[31:DEC_W], s_araddr[1:0]};

  assign aw_hs   = s_awvalid & awready_q;
  assign w_hs    = s_wvalid & wready_q;
  assign ar_hs   = s_arvalid & arready_q;
  assign wr_idx  = aw_held_q ? awidx_q : s_awaddr[DEC_W-1:2];
  assign wr_data = w_held_q ? wdata_q : s_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_wstrb;
  assign rd_idx  = s_araddr[DEC_W-1:2];
  assign commit  = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_resp = (wr_idx <= A_VERSION) ? RESP_OKAY : RESP_UNMAP;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    merge_bytes = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge_bytes[8*b +: 8] = new_v[8*b +: 8];
    end
  endfunction

  // Write channel: AW and W may arrive in either order; the update commits once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_resp;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_awaddr[DEC_W-1:2];
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
          end
        end
      end
      W_RESP: if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    // NOTE: readies are registered so they stay low while rst is held and rise one cycle after release.
    awready_d = (w_state_d == W_IDLE) & ~aw_held_d;
    wready_d  = (w_state_d == W_IDLE) & ~w_held_d;
  end

  always_comb begin
    irq_en_d  = irq_en_q;
    fb_lo_d   = fb_lo_q;
    fb_hi_d   = fb_hi_q;
    scratch_d = scratch_q;
    done_d    = done_q;
    start_d   = 1'b0;
    if (commit) begin
      case (wr_idx)
        A_CTRL: begin
          if (wr_strb[0]) begin
            irq_en_d = wr_data[1];
            start_d  = wr_data[0];
          end
        end
        A_STATUS:  if (wr_strb[0] && wr_data[1]) done_d = 1'b0;
        A_FB_LO:   fb_lo_d   = merge_bytes(fb_lo_q, wr_data, wr_strb);
        A_FB_HI:   fb_hi_d   = merge_bytes(fb_hi_q, wr_data, wr_strb);
        A_SCRATCH: scratch_d = merge_bytes(scratch_q, wr_data, wr_strb);
        default: ;
      endcase
    end
    // NOTE: the set is applied after the W1C so a same-cycle clear can never hide a completed frame.
    if (eng_done) done_d = 1'b1;
  end

  assign frame_cnt_d = eng_done ? frame_cnt_q + 32'd1 : frame_cnt_q;

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      A_CTRL:      rd_val = {30'd0, irq_en_q, 1'b0};
      A_STATUS:    rd_val = {30'd0, done_q, eng_busy};
      A_FB_LO:     rd_val = fb_lo_q;
      A_FB_HI:     rd_val = fb_hi_q;
      A_FRAME_CNT: rd_val = frame_cnt_q;
      A_SCRATCH:   rd_val = scratch_q;
      A_VERSION:   rd_val = VERSION;
      default:     rd_resp = RESP_UNMAP;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = rd_val;
          rresp_d   = rd_resp;
        end
      end
      R_DATA: if (s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awidx_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= '0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      fb_lo_q     <= '0;
      fb_hi_q     <= '0;
      scratch_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awidx_q     <= awidx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      start_q     <= start_d;
      irq_q       <= done_q & irq_en_q;
      fb_lo_q     <= fb_lo_d;
      fb_hi_q     <= fb_hi_d;
      scratch_q   <= scratch_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign eng_start = start_q;
  assign fb_addr   = {fb_hi_q, fb_lo_q};
  assign irq       = irq_q;

endmodule

// File: tb/tb_cl_ocl_csr.sv
// tb_cl_ocl_csr: directed and randomized AXI-Lite traffic against a register-map model of cl_ocl_csr.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_cl_ocl_csr;
  localparam logic [31:0] VER = 32'h3D00_0001;
  localparam int          TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_start;
  logic [63:0] fb_addr;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;
  int starts_seen = 0;

  logic        m_irq_en, m_done;
  logic [31:0] m_fb_lo, m_fb_hi, m_scratch, m_cnt;
  int          m_starts = 0;

  cl_ocl_csr dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_start(eng_start),
    .fb_addr(fb_addr), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start) starts_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_irq_en = 1'b0; m_done = 1'b0;
    m_fb_lo = '0; m_fb_hi = '0; m_scratch = '0; m_cnt = '0;
  endtask

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
    logic [7:0] off;
    off  = addr[7:0] & 8'hFC;
    resp = 2'b00;
    case (off)
      8'h00: if (strb[0]) begin m_irq_en = data[1]; if (data[0]) m_starts++; end
      8'h04: if (strb[0] && data[1]) m_done = 1'b0;
      8'h08: m_fb_lo   = strb_merge(m_fb_lo, data, strb);
      8'h0C: m_fb_hi   = strb_merge(m_fb_hi, data, strb);
      8'h14: m_scratch = strb_merge(m_scratch, data, strb);
      8'h10, 8'h18: ;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input logic [31:0] addr, input logic busy,
                            output logic [31:0] data, output logic [1:0] resp);
    logic [7:0] off;
    off  = addr[7:0] & 8'hFC;
    data = '0;
    resp = 2'b00;
    case (off)
      8'h00: data = m_irq_en ? 32'h2 : 32'h0;
      8'h04: data = (m_done ? 32'h2 : 32'h0) + (busy ? 32'h1 : 32'h0);
      8'h08: data = m_fb_lo;
      8'h0C: data = m_fb_hi;
      8'h10: data = m_cnt;
      8'h14: data = m_scratch;
      8'h18: data = VER;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    m_done   = 1'b1;
    m_cnt    = m_cnt + 32'd1;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_hold, input bit leave_b,
                          input logic [1:0] exp_resp, input string tag);
    int c = 0;
    int b_lat = 0;
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    while (!(aw_done && w_done)) begin
      if (c == aw_dly) begin s_awaddr = addr; s_awvalid = 1'b1; end
      if (c == w_dly)  begin s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; end
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      @(negedge clk);
      if (hs_aw) begin s_awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin s_wvalid = 1'b0; w_done = 1'b1; end
      c++;
      if (c > TMO) begin
        check({tag, "_addr_data_timeout"}, 0, 1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        return;
      end
    end
    while (!s_bvalid) begin
      if (b_lat >= TMO) begin check({tag, "_b_timeout"}, 0, 1); return; end
      @(negedge clk);
      b_lat++;
    end
    check({tag, "_b_latency"}, b_lat, 0);
    check({tag, "_bresp"}, s_bresp, exp_resp);
    if (leave_b) return;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, s_bvalid, 1);
      check({tag, "_bresp_hold"}, s_bresp, exp_resp);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check({tag, "_bvalid_drop"}, s_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int ar_dly, input int r_hold, input bit leave_r, input string tag);
    int c = 0;
    bit hs;
    repeat (ar_dly) @(negedge clk);
    s_araddr  = addr;
    s_arvalid = 1'b1;
    forever begin
      hs = s_arready;
      @(negedge clk);
      if (hs) break;
      c++;
      if (c > TMO) begin
        check({tag, "_ar_timeout"}, 0, 1);
        s_arvalid = 1'b0;
        return;
      end
    end
    s_arvalid = 1'b0;
    check({tag, "_rvalid"}, s_rvalid, 1);
    check({tag, "_rdata"}, s_rdata, exp_data);
    check({tag, "_rresp"}, s_rresp, exp_resp);
    if (leave_r) return;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      check({tag, "_rvalid_hold"}, s_rvalid, 1);
      check({tag, "_rdata_hold"}, s_rdata, exp_data);
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check({tag, "_rvalid_drop"}, s_rvalid, 0);
  endtask

  initial begin
    logic [1:0]  er;
    logic [31:0] ed, a, d;
    logic [3:0]  st;
    int          sel;

    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_irq", irq, 0);
    check("rst_fb_addr", fb_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", s_awready, 1);
    check("post_rst_wready", s_wready, 1);
    check("post_rst_arready", s_arready, 1);

    do_read(32'h18, VER, 2'b00, 0, 0, 1'b0, "version");

    // Data arrives three cycles ahead of the address.
    model_write(32'h14, 32'hA5A5_5A5A, 4'b0101, er);
    do_write(32'h14, 32'hA5A5_5A5A, 4'b0101, 3, 0, 0, 1'b0, 2'b00, "w_before_aw");
    do_read(32'h14, 32'h00A5_005A, 2'b00, 0, 0, 1'b0, "scratch_strb");

    model_write(32'h00, 32'h3, 4'hF, er);
    do_write(32'h00, 32'h3, 4'hF, 0, 0, 0, 1'b0, 2'b00, "ctrl_start");
    @(negedge clk);
    check("start_one_pulse", starts_seen, 1);
    check("irq_before_done", irq, 0);
    pulse_done();
    check("irq_after_done", irq, 1);
    do_read(32'h04, 32'h2, 2'b00, 0, 0, 1'b0, "status_done");
    do_read(32'h10, 32'h1, 2'b00, 0, 0, 1'b0, "frame_cnt_1");

    // eng_done coincides with the W1C commit: set wins.
    eng_done  = 1'b1;
    s_awaddr  = 32'h04; s_awvalid = 1'b1;
    s_wdata   = 32'h2;  s_wstrb   = 4'hF; s_wvalid = 1'b1;
    check("w1c_race_ready", s_awready & s_wready, 1);
    @(negedge clk);
    eng_done = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    m_cnt = m_cnt + 32'd1;
    check("w1c_race_bvalid", s_bvalid, 1);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    do_read(32'h04, 32'h2, 2'b00, 0, 0, 1'b0, "done_set_wins");
    check("irq_held", irq, 1);
    model_write(32'h04, 32'h2, 4'hF, er);
    do_write(32'h04, 32'h2, 4'hF, 1, 0, 0, 1'b0, 2'b00, "w1c_clear");
    check("irq_cleared", irq, 0);
    do_read(32'h04, 32'h0, 2'b00, 0, 0, 1'b0, "done_cleared");
    do_read(32'h10, 32'h2, 2'b00, 0, 0, 1'b0, "frame_cnt_2");

    do_read(32'h40, 32'h0, 2'b10, 0, 2, 1'b0, "unmapped_rd");
    do_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 5, 1'b0, 2'b10, "unmapped_wr");
    do_read(32'h14, m_scratch, 2'b00, 0, 0, 1'b0, "unmapped_no_change");

    for (int i = 0; i < 200; i++) begin
      eng_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) pulse_done();
      sel = int'($urandom_range(0, 8));
      a   = $urandom;
      if (sel <= 6)      a[7:0] = 8'(sel * 4 + int'($urandom_range(0, 3)));
      else if (sel == 7) a[7:0] = 8'(8'h1C + 4 * int'($urandom_range(0, 56)) + int'($urandom_range(0, 3)));
      d  = $urandom;
      st = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        model_write(a, d, st, er);
        do_write(a, d, st, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'b0, er, "rnd_wr");
        check("rnd_irq", irq, m_done & m_irq_en);
        check("rnd_fb_addr", fb_addr, {m_fb_hi, m_fb_lo});
      end else begin
        model_read(a, eng_busy, ed, er);
        do_read(a, ed, er, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, "rnd_rd");
      end
    end
    eng_busy = 1'b0;
    @(negedge clk);
    check("start_count", starts_seen, m_starts);

    // Leave one write response and one read response pending, then reset.
    model_write(32'h14, 32'h1234_5678, 4'hF, er);
    do_write(32'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b1, 2'b00, "pend_wr");
    do_read(32'h08, m_fb_lo, 2'b00, 0, 0, 1'b1, "pend_rd");
    check("pend_bvalid", s_bvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bvalid", s_bvalid, 0);
    check("async_rst_rvalid", s_rvalid, 0);
    check("async_rst_awready", s_awready, 0);
    check("async_rst_arready", s_arready, 0);
    check("async_rst_fb_addr", fb_addr, 0);
    check("async_rst_irq", irq, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst_awready", s_awready, 1);
    check("rerst_arready", s_arready, 1);
    do_read(32'h08, 32'h0, 2'b00, 0, 0, 1'b0, "rst_fb_lo");
    do_read(32'h0C, 32'h0, 2'b00, 0, 0, 1'b0, "rst_fb_hi");
    do_read(32'h14, 32'h0, 2'b00, 0, 0, 1'b0, "rst_scratch");
    do_read(32'h10, 32'h0, 2'b00, 0, 0, 1'b0, "rst_frame_cnt");

    force dut.frame_cnt_d = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt_d;
    m_cnt = 32'hFFFF_FFFF;
    do_read(32'h10, 32'hFFFF_FFFF, 2'b00, 0, 0, 1'b0, "frame_cnt_max");
    pulse_done();
    do_read(32'h10, 32'h0, 2'b00, 0, 0, 1'b0, "frame_cnt_wrap");
    do_read(32'h04, 32'h2, 2'b00, 0, 0, 1'b0, "done_after_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
